// File: rtl/syn_current_accum.sv
// rtl/syn_current_accum.sv - synaptic weight RAM and IEEE-754 current accumulator
// fp32_add is the single-precision adder; syn_current_accum scans the RAM and sums spiking synapses.
module fp32_add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  logic [31:0] w_big, w_small;
  logic [7:0]  w_eb, w_es, w_diff;
  logic [26:0] w_mb, w_ms, w_ms_sh, w_norm;
  logic [27:0] w_raw;
  logic [8:0]  w_exp;
  logic [4:0]  w_lz, w_sh;
  logic [24:0] w_rnd;
  logic        w_up;

  always_comb begin
    w_big   = i_b;
    w_small = i_a;
    if (i_a[30:0] >= i_b[30:0]) begin
      w_big   = i_a;
      w_small = i_b;
    end
    // subnormals share exponent 1 with no hidden bit; 3 extra LSBs hold guard/round/sticky
    w_eb   = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    w_es   = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
    w_mb   = {w_big[30:23] != 8'd0, w_big[22:0], 3'b000};
    w_ms   = {w_small[30:23] != 8'd0, w_small[22:0], 3'b000};
    w_diff = w_eb - w_es;
    if (w_diff > 8'd26) begin
      w_ms_sh = {26'd0, |w_ms};
    end else begin
      w_ms_sh    = w_ms >> w_diff;
      w_ms_sh[0] = w_ms_sh[0] | (|(w_ms & ~(27'h7ffffff << w_diff)));
    end
    if (w_big[31] == w_small[31]) w_raw = {1'b0, w_mb} + {1'b0, w_ms_sh};
    else                          w_raw = {1'b0, w_mb} - {1'b0, w_ms_sh};

    w_exp  = {1'b0, w_eb};
    w_lz   = 5'd27;
    w_sh   = 5'd0;
    w_norm = w_raw[26:0];
    if (w_raw[27]) begin
      w_norm = {w_raw[27:2], w_raw[1] | w_raw[0]};
      w_exp  = w_exp + 9'd1;
    end else begin
      for (int k = 0; k < 27; k++) if (w_raw[k]) w_lz = 5'(26 - k);
      w_sh   = ({4'd0, w_lz} > (w_exp - 9'd1)) ? 5'(w_exp - 9'd1) : w_lz;
      w_norm = w_raw[26:0] << w_sh;
      w_exp  = w_exp - {4'd0, w_sh};
    end

    w_up  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_up};
    if (w_rnd[24]) begin
      w_rnd = {1'b0, w_rnd[24:1]};
      w_exp = w_exp + 9'd1;
    end

    if (w_raw == 28'd0)       o_sum = 32'h0;
    else if (w_exp >= 9'd255) o_sum = {w_big[31], 8'hff, 23'd0};
    else if (!w_rnd[23])      o_sum = {w_big[31], 8'd0, w_rnd[22:0]};
    else                      o_sum = {w_big[31], w_exp[7:0], w_rnd[22:0]};
  end
endmodule

module syn_current_accum #(
  parameter int NEURON_ADR = 8,
  parameter int WEIGHTS    = 31,
  parameter int SYN_NUM    = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [SYN_NUM-1:0]    i_pre_spikes,
  input  logic                  i_we,
  input  logic [NEURON_ADR:0]   i_addr,
  input  logic [WEIGHTS:0]      i_weight,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [WEIGHTS:0]      o_i_syn
);
  localparam int IDX_W  = $clog2(SYN_NUM);
  localparam int ADDR_W = NEURON_ADR + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYN_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FINISH} state_t;

  state_t               r_state, w_next;
  logic [IDX_W-1:0]     r_idx;
  logic [WEIGHTS:0]     r_acc, r_i_syn, w_sum, w_rd;
  logic [SYN_NUM-1:0]   r_snap;
  logic                 r_done;
  logic [WEIGHTS:0]     r_mem [SYN_NUM];
  logic                 w_busy, w_load, w_scan, w_finish;

  assign w_rd = r_mem[r_idx];

  fp32_add u_add (
    .i_a   (r_acc),
    .i_b   (w_rd),
    .o_sum (w_sum)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_SCAN;
      S_SCAN:   if (r_idx == LAST_IDX) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_load   = (r_state == S_IDLE) && i_start;
    w_scan   = (r_state == S_SCAN);
    w_finish = (r_state == S_FINISH);
  end

  // RAM write uses NBA, so a SCAN read of the same word this cycle sees the old value
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx   <= '0;
      r_acc   <= '0;
      r_snap  <= '0;
      r_done  <= 1'b0;
      r_i_syn <= '0;
      for (int k = 0; k < SYN_NUM; k++) r_mem[k] <= '0;
    end else begin
      if (w_load) begin
        r_snap <= i_pre_spikes;
        r_acc  <= '0;
        r_idx  <= '0;
      end
      if (w_scan) begin
        if (r_snap[r_idx]) r_acc <= w_sum;
        if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
      end
      r_done <= w_finish;
      if (w_finish) r_i_syn <= r_acc;
      for (int k = 0; k < SYN_NUM; k++)
        if (i_we && i_addr == ADDR_W'(k)) r_mem[k] <= i_weight;
    end
  end

  assign o_busy  = w_busy;
  assign o_done  = r_done;
  assign o_i_syn = r_i_syn;
endmodule
